// File: rtl/fifo_out_drain.sv
// rtl/fifo_out_drain.sv - bus master that polls the output FIFO slave and drains words onto a valid/ready stream
// Flags are polled before every data read, so a read never races the slave's one-cycle-late flag register.
module fifo_out_drain #(
  parameter logic [7:0] FLAG_ADDR = 8'h20,
  parameter logic [7:0] DATA_ADDR = 8'h21,
  parameter int         EMPTY_BIT = 4,
  parameter int         RDERR_BIT = 0,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             err_clr,
  output logic             m_sel,
  output logic             m_wr,
  output logic [7:0]       m_address,
  input  logic [31:0]      m_din,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] drain_count,
  output logic             err_sticky
);

  typedef enum logic [2:0] {
    IDLE,
    POLL_REQ,
    POLL_WAIT,
    RD_REQ,
    RD_WAIT,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        sel_nx;
  logic [7:0]  addr_nx;
  logic        stop_q;

  // stop_q remembers that enable fell while the poll was on the bus, so that
  // poll ends in IDLE without starting a read even if the FIFO has data.
  always_comb begin
    state_nx = state;
    sel_nx   = 1'b0;
    addr_nx  = 8'h00;
    case (state)
      IDLE:      if (enable) state_nx = POLL_REQ;
      POLL_REQ:  state_nx = POLL_WAIT;
      POLL_WAIT: begin
        if (stop_q)
          state_nx = IDLE;
        else if (m_din[EMPTY_BIT])
          state_nx = enable ? POLL_REQ : IDLE;
        else
          state_nx = RD_REQ;
      end
      RD_REQ:    state_nx = RD_WAIT;
      RD_WAIT:   state_nx = HOLD;
      HOLD:      if (out_ready) state_nx = enable ? POLL_REQ : IDLE;
      default:   state_nx = IDLE;
    endcase
    // Bus outputs are registered from the next state, so they line up with the request states.
    if (state_nx == POLL_REQ) begin
      sel_nx  = 1'b1;
      addr_nx = FLAG_ADDR;
    end else if (state_nx == RD_REQ) begin
      sel_nx  = 1'b1;
      addr_nx = DATA_ADDR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      m_sel       <= 1'b0;
      m_address   <= 8'h00;
      stop_q      <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 32'h0;
      drain_count <= '0;
      err_sticky  <= 1'b0;
    end else begin
      state     <= state_nx;
      m_sel     <= sel_nx;
      m_address <= addr_nx;
      if (state == POLL_REQ)
        stop_q <= ~enable;
      // A new RD_ERR outranks a clear arriving in the same cycle.
      if (state == POLL_WAIT && m_din[RDERR_BIT])
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;
      if (state == RD_WAIT) begin
        out_data  <= m_din;
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid   <= 1'b0;
        drain_count <= drain_count + 1'b1;
      end
    end
  end

  assign m_wr = 1'b0;
  assign busy = (state != IDLE);

endmodule
